// File: rtl/spi_slave_regfile.sv
// SPI slave with an internal register file. The SPI pins are oversampled in the clk domain.
// Frame layout, MSB first: R/W bit (1 = read), then ADDR_W address bits, then DATA_W data bits.
module spi_slave_regfile #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              csz,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err
);

    localparam int unsigned L     = 1 + ADDR_W + DATA_W;
    localparam int unsigned CW    = $clog2(L + 1);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [CW-1:0] CntAddrEnd    = CW'(ADDR_W);
    localparam logic [CW-1:0] CntFirstShift = CW'(ADDR_W + 2);
    localparam logic [CW-1:0] CntLast       = CW'(L - 1);
    localparam logic [CW-1:0] CntMax        = CW'(L);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csz_sync_q, sdi_sync_q;
    logic sclk_prev_q, csz_prev_q;
    logic sclk_s, csz_s, sdi_s;
    logic sclk_rise, sclk_fall, sample_edge, shift_edge, csz_fall, csz_rise;

    logic [CW-1:0]     cnt_q;
    logic              rw_q, load_q, commit_q, shift_dly_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rx_q, tx_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic sdo_q, sdo_d, oe_q, oe_d, frame_err_q, frame_err_d;
    logic [DATA_W-1:0] host_rdata_q, wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_valid_q;

    // Everything resets to 0, so a csz held low through reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            csz_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            csz_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            csz_sync_q  <= {csz_sync_q[SYNC_STAGES-2:0], csz};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            sclk_prev_q <= sclk_s;
            csz_prev_q  <= csz_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign csz_s       = csz_sync_q[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
    assign csz_fall    = csz_prev_q & ~csz_s;
    assign csz_rise    = ~csz_prev_q & csz_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sdo_q       <= 1'b0;
            oe_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sdo_q       <= sdo_d;
            oe_q        <= oe_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (csz_fall) state_d = StCmd;
            StCmd: begin
                if (csz_rise) state_d = StIdle;
                else if (sample_edge) state_d = StAddr;
            end
            StAddr: begin
                if (csz_rise) state_d = StIdle;
                else if (sample_edge && cnt_q == CntAddrEnd) state_d = StData;
            end
            StData: begin
                if (csz_rise) state_d = StIdle;
                else if (sample_edge && cnt_q == CntLast) state_d = StDone;
            end
            StDone: if (csz_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_err_d = csz_rise && (state_q inside {StCmd, StAddr, StData});
        oe_d        = (state_d != StIdle);
        sdo_d       = 1'b0;
        if (state_d == StData && rw_q) begin
            if (CPHA == 0) sdo_d = tx_q[DATA_W-1];
            else           sdo_d = shift_dly_q ? tx_q[DATA_W-1] : sdo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            load_q      <= 1'b0;
            commit_q    <= 1'b0;
            shift_dly_q <= 1'b0;
        end else begin
            load_q      <= 1'b0;
            commit_q    <= 1'b0;
            shift_dly_q <= shift_edge;
            if (state_q == StIdle && csz_fall) begin
                cnt_q <= '0;
            end else if (sample_edge && !csz_rise && (state_q inside {StCmd, StAddr, StData})) begin
                if (cnt_q != CntMax) cnt_q <= cnt_q + CW'(1);
                case (state_q)
                    StCmd:  rw_q <= sdi_s;
                    StAddr: begin
                        addr_q <= (addr_q << 1) | ADDR_W'(sdi_s);
                        if (cnt_q == CntAddrEnd) load_q <= rw_q;
                    end
                    StData: begin
                        rx_q <= (rx_q << 1) | DATA_W'(sdi_s);
                        if (cnt_q == CntLast) commit_q <= ~rw_q;
                    end
                    default: ;
                endcase
            end
            // The shift edge right before the first data sample must keep the MSB on sdo.
            if (state_q == StIdle && csz_fall) begin
                tx_q <= '0;
            end else if (load_q) begin
                tx_q <= mem_q[addr_q];
            end else if (shift_edge && state_q == StData && rw_q && cnt_q >= CntFirstShift) begin
                tx_q <= tx_q << 1;
            end
        end
    end

    // SPI commit is written after the host write so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            host_rdata_q <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            host_rdata_q <= mem_q[host_addr];
            wr_valid_q   <= commit_q;
            if (host_we) mem_q[host_addr] <= host_wdata;
            if (commit_q) begin
                mem_q[addr_q] <= rx_q;
                wr_addr_q     <= addr_q;
                wr_data_q     <= rx_q;
            end
        end
    end

    assign sdo        = sdo_q;
    assign sdo_oe     = oe_q;
    assign frame_err  = frame_err_q;
    assign host_rdata = host_rdata_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule
